carry_chain_seq: RTL and testbench

Multi-cycle sequencer that performs a WIDTH-bit add (or subtract) through a single shared 4-bit CARRY4-style slice. Each cycle it feeds one nibble of the operands into the slice and registers the carry-out back into the next cycle's carry-in. It sits between a valid/ready operand source and a valid/ready result sink, trading latency for one carry-chain slice instead of WIDTH/4 cascaded slices.

---
 rtl/carry_seq_pkg.sv | 17 +
 rtl/carry4_slice.sv | 25 ++
 rtl/carry_chain_seq.sv | 128 ++++++++++++
 tb/tb_carry_chain_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/carry_seq_pkg.sv
// Shared definitions for the carry-chain sequencer: slice width, FSM states
// and slice-count helper.
package carry_seq_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned nslices(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/carry4_slice.sv
// Behavioural CARRY4-style slice: 4-bit mux carry chain with XOR sum outputs.
module carry4_slice
  import carry_seq_pkg::*;
(
  input  logic               ci,
  input  logic               cyinit,
  input  logic [SLICE_W-1:0] di,
  input  logic [SLICE_W-1:0] s,
  output logic [SLICE_W-1:0] co,
  output logic [SLICE_W-1:0] o
);

  always_comb begin
    logic w_c;
    co  = '0;
    o   = '0;
    w_c = ci | cyinit;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      o[i]  = s[i] ^ w_c;
      co[i] = s[i] ? w_c : di[i];
      w_c   = co[i];
    end
  end

endmodule

// File: rtl/carry_chain_seq.sv
// WIDTH-bit add/subtract sequenced nibble-by-nibble through one carry4_slice.
// Subtraction is built only when CARRY_SEQ_SUB_EN is defined.
module carry_chain_seq
  import carry_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NSL   = nslices(WIDTH);
  localparam int unsigned IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_width_check
    $error("carry_chain_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t             r_state, w_next_state;
  logic [WIDTH-1:0]   r_a, r_b, r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_cin, r_carry, r_cout, r_ovf;
  logic [WIDTH-1:0]   w_b_eff;
  logic               w_cin_eff, w_last, w_ci, w_cyinit;
  logic [SLICE_W-1:0] w_di, w_s, w_co, w_o;

`ifdef CARRY_SEQ_SUB_EN
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = cin ^ sub;
`else
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_b_eff      = b;
  assign w_cin_eff    = cin;
`endif

  assign w_last   = (r_idx == LAST_IDX);
  assign w_di     = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_s      = w_di ^ r_b[r_idx*SLICE_W +: SLICE_W];
  // Operation carry-in enters only on the first nibble; later nibbles chain
  // the registered carry-out of the previous cycle.
  assign w_cyinit = (r_idx == '0) ? r_cin : 1'b0;
  assign w_ci     = (r_idx != '0) ? r_carry : 1'b0;

  carry4_slice u_slice (
    .ci     (w_ci),
    .cyinit (w_cyinit),
    .di     (w_di),
    .s      (w_s),
    .co     (w_co),
    .o      (w_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next_state = RUN;
      RUN:     if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_cin   <= w_cin_eff;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        RUN: begin
          r_sum[r_idx*SLICE_W +: SLICE_W] <= w_o;
          r_carry <= w_co[SLICE_W-1];
          if (w_last) begin
            r_cout <= w_co[SLICE_W-1];
            r_ovf  <= w_co[SLICE_W-1] ^ w_co[SLICE_W-2];
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = rst_n && (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_carry_chain_seq.sv
// Directed bench for carry_chain_seq at WIDTH=16 and WIDTH=4.
module tb_carry_chain_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
  logic [15:0] a, b, sum;

  logic       in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, ovf4, busy4;
  logic [3:0] a4, b4, sum4;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  carry_chain_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  carry_chain_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge; returns whether the DUT was ready at that edge.
  task automatic start16(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts, output logic was_ready);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    was_ready = in_ready;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid16(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain16();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                      input logic tc, input logic ts,
                      input logic [15:0] esum, input logic ecout, input logic eovf);
    logic rdy;
    int   lat;
    start16(ta, tb_v, tc, ts, rdy);
    check({tag, "_accept"}, rdy, 1);
    wait_valid16(lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum, esum);
    check({tag, "_cout"}, cout, ecout);
    check({tag, "_ovf"}, ovf, eovf);
    drain16();
    check({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic        rdy;
    int          lat;
    int          seen;
    logic [15:0] exp_sub;

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;

    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout_ovf", {cout, ovf}, 2'b00);
    check("rst_busy", busy, 0);
    #3 rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    op16("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16("cin1", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
`ifdef CARRY_SEQ_SUB_EN
    exp_sub = 16'hFFFE;
`else
    exp_sub = 16'h000C;
`endif
    op16("sub", 16'h0005, 16'h0007, 1'b0, 1'b1, exp_sub, 1'b0, 1'b0);

    // Backpressure: result held, new operands refused until handshake done.
    start16(16'h8000, 16'h8000, 1'b0, 1'b0, rdy);
    check("bp_accept", rdy, 1);
    wait_valid16(lat);
    check("bp_latency", lat, 4);
    a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid_rdy", {out_valid, in_ready}, 2'b10);
      check("bp_hold_sum", sum, 16'h0000);
      check("bp_hold_cout_ovf", {cout, ovf}, 2'b11);
      tick();
    end
    check("bp_hold_final", {out_valid, in_ready, sum}, {2'b10, 16'h0000});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_back_idle", {busy, in_ready, out_valid}, 3'b010);
    tick();
    in_valid = 1'b0;
    check("bp_next_accepted", busy, 1);
    wait_valid16(lat);
    check("bp_next_latency", lat, 4);
    check("bp_next_sum", sum, 16'h0003);
    drain16();

    // Reset while RUN is on nibble 2: partial result must vanish immediately.
    start16(16'h1234, 16'h1111, 1'b0, 1'b0, rdy);
    check("rr_accept", rdy, 1);
    tick();
    tick();
    check("rr_partial", {busy, sum}, {1'b1, 16'h0045});
    rst_n = 1'b0;
    #1;
    check("rr_sum_zero", sum, 16'h0000);
    check("rr_flags_zero", {out_valid, busy, cout, ovf}, 4'b0000);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("rr_no_valid", seen, 0);
    op16("rr_next", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    // WIDTH=4: single RUN cycle.
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; in_valid4 = 1'b1;
    check("w4_ready", in_ready4, 1);
    tick();
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      tick();
      lat++;
    end
    check("w4_latency", lat, 1);
    check("w4_result", {sum4, cout4, ovf4}, {4'h1, 1'b1, 1'b1});
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    a4 = 4'h7; b4 = 4'h1; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      tick();
      lat++;
    end
    check("w4b_latency", lat, 1);
    check("w4b_result", {sum4, cout4, ovf4}, {4'h8, 1'b0, 1'b1});
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    check("w4b_idle", {out_valid4, in_ready4}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
